program_loader: RTL and testbench

- Upstream stage of the 8-bit crypto processor control unit.
- Receives a framed byte stream (program and operand image) over a valid/ready handshake and writes each byte into the processor memory through the control unit's manual-write path (data, address, write-enable).
- Holds the processor core in reset while loading. Releases it only after the frame checksum verifies, so instruction fetch starts at PC 0 on a complete image.

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes payload bytes into processor memory and holds
// the core in reset until the frame checksum verifies. Optional LOADER_TIMEOUT_EN adds an inter-byte timeout.
module program_loader #(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] ld_data,
    output logic [7:0] ld_addr,
    output logic       ld_we,
    output logic       cpu_rst,
    output logic       done,
    output logic [1:0] err,
    output logic [7:0] load_count
);

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR
    } state_t;

    state_t      state, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  count_d, data_d, addr_d;
    logic [7:0]  csum_chk;
    logic [1:0]  err_d;
    logic        xfer;
`ifdef LOADER_TIMEOUT_EN
    logic [15:0] idle_cnt, idle_d;
`endif

    assign xfer     = in_valid && in_ready;
    assign csum_chk = sum_q + in_data;

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        len_d   = len_q;
        sum_d   = sum_q;
        count_d = load_count;
        data_d  = ld_data;
        addr_d  = ld_addr;
        err_d   = err;
`ifdef LOADER_TIMEOUT_EN
        idle_d  = 16'd0;
`endif
        case (state)
            IDLE, ERROR: begin
                if (xfer && in_data == SYNC_BYTE) begin
                    state_d = LEN;
                    err_d   = 2'd0;
                    count_d = 8'd0;
                    sum_d   = 8'd0;
                end
            end
            LEN: begin
                if (xfer) begin
                    len_d   = in_data;
                    sum_d   = in_data;
                    state_d = (in_data == 8'd0) ? CSUM : DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    data_d  = in_data;
                    addr_d  = BASE_ADDR + load_count;
                    sum_d   = csum_chk;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                count_d = load_count + 8'd1;
                state_d = (count_d == len_q) ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) begin
                    if (csum_chk == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_d   = 2'd1;
                    end
                end
            end
            DONE:    ;
            default: state_d = IDLE;
        endcase
`ifdef LOADER_TIMEOUT_EN
        // Counter restarts on any transfer and on entry to a waiting state.
        if ((state == LEN || state == DATA || state == CSUM) && !xfer) begin
            if (idle_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                state_d = ERROR;
                err_d   = 2'd2;
            end else begin
                idle_d = idle_cnt + 16'd1;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= 8'd0;
            sum_q      <= 8'd0;
            load_count <= 8'd0;
            ld_data    <= 8'd0;
            ld_addr    <= 8'd0;
            err        <= 2'd0;
            in_ready   <= 1'b0;
            ld_we      <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt   <= 16'd0;
`endif
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            load_count <= count_d;
            ld_data    <= data_d;
            ld_addr    <= addr_d;
            err        <= err_d;
            // Handshake/control outputs are registered from the next state.
            in_ready   <= !(state_d == WRITE || state_d == DONE);
            ld_we      <= (state_d == WRITE);
            cpu_rst    <= (state_d != DONE);
            done       <= (state_d == DONE);
`ifdef LOADER_TIMEOUT_EN
            idle_cnt   <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; a second instance with BASE_ADDR=FE
// shares the same input stream and is checked for address wrap.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready0, ld_we0, cpu_rst0, done0;
    logic [7:0] ld_data0, ld_addr0, load_count0;
    logic [1:0] err0;
    logic       in_ready1, ld_we1, cpu_rst1, done1;
    logic [7:0] ld_data1, ld_addr1, load_count1;
    logic [1:0] err1;

    int checks   = 0;
    int failures = 0;
    int we_ready_viol = 0;
    logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(8'h00), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .ld_data(ld_data0), .ld_addr(ld_addr0), .ld_we(ld_we0),
        .cpu_rst(cpu_rst0), .done(done0), .err(err0), .load_count(load_count0)
    );

    program_loader #(.BASE_ADDR(8'hFE), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .ld_data(ld_data1), .ld_addr(ld_addr1), .ld_we(ld_we1),
        .cpu_rst(cpu_rst1), .done(done1), .err(err1), .load_count(load_count1)
    );

    // Memory-write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (ld_we0) begin
            wa0.push_back(ld_addr0);
            wd0.push_back(ld_data0);
            if (in_ready0) we_ready_viol++;
        end
        if (ld_we1) begin
            wa1.push_back(ld_addr1);
            wd1.push_back(ld_data1);
            if (in_ready1) we_ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_log();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    endtask

    task automatic send(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready0) begin
            checks++;
            failures++;
            $display("FAIL send_stall byte=%h observed in_ready=0 expected in_ready=1", b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_log();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] a,
                               input logic [7:0] d, input bit inst1);
        if (inst1) begin
            check({tag, "_addr"}, {8'h0, wa1[idx]}, {8'h0, a});
            check({tag, "_data"}, {8'h0, wd1[idx]}, {8'h0, d});
        end else begin
            check({tag, "_addr"}, {8'h0, wa0[idx]}, {8'h0, a});
            check({tag, "_data"}, {8'h0, wd0[idx]}, {8'h0, d});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_in_ready",   {15'h0, in_ready0}, 16'h0);
        check("rst_cpu_rst",    {15'h0, cpu_rst0},  16'h1);
        check("rst_done",       {15'h0, done0},     16'h0);
        check("rst_ld_we",      {15'h0, ld_we0},    16'h0);
        check("rst_err",        {14'h0, err0},      16'h0);
        check("rst_ld_addr",    {8'h0, ld_addr0},   16'h0);
        check("rst_ld_data",    {8'h0, ld_data0},   16'h0);
        check("rst_load_count", {8'h0, load_count0}, 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", {15'h0, in_ready0}, 16'h1);

        // Nominal load
        send(8'hA5); send(8'h03); send(8'h20); send(8'h11); send(8'h30);
        check("nom_cpu_rst_before", {15'h0, cpu_rst0}, 16'h1);
        check("nom_done_before",    {15'h0, done0},    16'h0);
        send(8'h9C);
        check("nom_done",       {15'h0, done0},      16'h1);
        check("nom_cpu_rst",    {15'h0, cpu_rst0},   16'h0);
        check("nom_err",        {14'h0, err0},       16'h0);
        check("nom_load_count", {8'h0, load_count0}, 16'h3);
        check("nom_ready_done", {15'h0, in_ready0},  16'h0);
        check("nom_nwrites",    16'(wa0.size()),     16'h3);
        check_write("nom_w0", 0, 8'h00, 8'h20, 1'b0);
        check_write("nom_w1", 1, 8'h01, 8'h11, 1'b0);
        check_write("nom_w2", 2, 8'h02, 8'h30, 1'b0);

        // Bad checksum, then retry
        do_reset();
        send(8'hA5); send(8'h02); send(8'h30); send(8'h05); send(8'h00);
        check("bad_err",      {14'h0, err0},      16'h1);
        check("bad_cpu_rst",  {15'h0, cpu_rst0},  16'h1);
        check("bad_done",     {15'h0, done0},     16'h0);
        check("bad_in_ready", {15'h0, in_ready0}, 16'h1);
        check("bad_nwrites",  16'(wa0.size()),    16'h2);
        check_write("bad_w0", 0, 8'h00, 8'h30, 1'b0);
        check_write("bad_w1", 1, 8'h01, 8'h05, 1'b0);
        clear_log();
        send(8'hA5); send(8'h01); send(8'h20); send(8'hDF);
        check("retry_done",       {15'h0, done0},      16'h1);
        check("retry_err",        {14'h0, err0},       16'h0);
        check("retry_cpu_rst",    {15'h0, cpu_rst0},   16'h0);
        check("retry_load_count", {8'h0, load_count0}, 16'h1);
        check("retry_nwrites",    16'(wa0.size()),     16'h1);
        check_write("retry_w0", 0, 8'h00, 8'h20, 1'b0);

        // Garbage then zero-length frame
        do_reset();
        send(8'h00); send(8'hFF); send(8'h13);
        idle(2);
        check("garb_nwrites", 16'(wa0.size()), 16'h0);
        check("garb_done",    {15'h0, done0},  16'h0);
        send(8'hA5); send(8'h00); send(8'h00);
        check("zlen_done",    {15'h0, done0},      16'h1);
        check("zlen_cpu_rst", {15'h0, cpu_rst0},   16'h0);
        check("zlen_nwrites", 16'(wa0.size()),     16'h0);
        check("zlen_count",   {8'h0, load_count0}, 16'h0);

        // Address wrap (BASE_ADDR=FE instance) with gapped valid
        do_reset();
        idle(1); send(8'hA5);
        idle(1); send(8'h03);
        idle(1); send(8'h01);
        idle(1); send(8'h02);
        idle(1); send(8'h03);
        idle(1); send(8'hF7);
        check("wrap_done",    {15'h0, done1},  16'h1);
        check("wrap_nwrites", 16'(wa1.size()), 16'h3);
        check_write("wrap_w0", 0, 8'hFE, 8'h01, 1'b1);
        check_write("wrap_w1", 1, 8'hFF, 8'h02, 1'b1);
        check_write("wrap_w2", 2, 8'h00, 8'h03, 1'b1);
        check("we_ready_low", 16'(we_ready_viol), 16'h0);

        // Reset mid-frame, with a SYNC byte offered during reset
        do_reset();
        send(8'hA5); send(8'h04); send(8'h10);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk); #1;
        check("mid_ld_we",      {15'h0, ld_we0},     16'h0);
        check("mid_ld_addr",    {8'h0, ld_addr0},    16'h0);
        check("mid_ld_data",    {8'h0, ld_data0},    16'h0);
        check("mid_load_count", {8'h0, load_count0}, 16'h0);
        check("mid_cpu_rst",    {15'h0, cpu_rst0},   16'h1);
        check("mid_in_ready",   {15'h0, in_ready0},  16'h0);
        check("mid_err",        {14'h0, err0},       16'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        clear_log();
        @(posedge clk); #1;
        send(8'hA5); send(8'h01); send(8'h55); send(8'hAA);
        check("mid_done",    {15'h0, done0}, 16'h1);
        check("mid_nwrites", 16'(wa0.size()), 16'h1);
        check_write("mid_w0", 0, 8'h00, 8'h55, 1'b0);

        // Inter-byte stall
        do_reset();
        send(8'hA5); send(8'h02); send(8'h10);
        idle(20);
        check("to_cpu_rst",  {15'h0, cpu_rst0},   16'h1);
        check("to_done",     {15'h0, done0},      16'h0);
        check("to_in_ready", {15'h0, in_ready0},  16'h1);
        check("to_count",    {8'h0, load_count0}, 16'h1);
`ifdef LOADER_TIMEOUT_EN
        check("to_err", {14'h0, err0}, 16'h2);
`else
        check("to_err", {14'h0, err0}, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
